// File: rtl/instr_loader.sv
// Buffered instruction loader: FIFO in front of an instruction-register write port.
// Optional macro INSTR_LOADER_DIVZERO_FILTER_EN drops DIV/MOD with a zero divisor.
package instr_register_pkg;
    typedef enum logic [3:0] {
        ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
    } opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0] address_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instr_t;
endpackage

module instr_loader
    import instr_register_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int START_PTR  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  opcode_t                       in_opcode,
    input  operand_t                      in_operand_a,
    input  operand_t                      in_operand_b,
    input  logic                          pause,
    output logic                          load_en,
    output address_t                      write_pointer,
    output opcode_t                       opcode,
    output operand_t                      operand_a,
    output operand_t                      operand_b,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    reject_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, PAUSED} state_t;

    state_t        state_q, state_d;
    instr_t        mem_q [FIFO_DEPTH];
    instr_t        mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          load_en_q, load_en_d;
    address_t      wp_q, wp_d;
    instr_t        out_q, out_d;
    logic [7:0]    rej_q, rej_d;

    logic   push;
    logic   pop;
    logic   drop;
    instr_t head;

    assign in_ready = !reset && (count_q != FULL);
    assign push     = in_valid && in_ready;
    // state_q != IDLE exactly when the buffer holds something
    assign pop      = (state_q != IDLE) && !pause;
    assign head     = mem_q[rd_ptr_q];

`ifdef INSTR_LOADER_DIVZERO_FILTER_EN
    assign drop = pop && ((head.opc == DIV) || (head.opc == MOD))
                      && (head.op_b == '0);
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{opc: in_opcode, op_a: in_operand_a,
                                op_b: in_operand_b};
        end
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        load_en_d = pop && !drop;
        out_d     = load_en_d ? head : out_q;
        wp_d      = load_en_q ? wp_q + 5'd1 : wp_q;
        rej_d     = (drop && rej_q != 8'hFF) ? rej_q + 8'd1 : rej_q;
        if (count_d == '0) begin
            state_d = IDLE;
        end else if (pause) begin
            state_d = PAUSED;
        end else begin
            state_d = ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            load_en_q <= 1'b0;
            wp_q      <= address_t'(START_PTR);
            out_q     <= '{opc: ZERO, op_a: '0, op_b: '0};
            rej_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            load_en_q <= load_en_d;
            wp_q      <= wp_d;
            out_q     <= out_d;
            rej_q     <= rej_d;
        end
        mem_q <= mem_d;
    end

    assign load_en       = load_en_q;
    assign write_pointer = wp_q;
    assign opcode        = out_q.opc;
    assign operand_a     = out_q.op_a;
    assign operand_b     = out_q.op_b;
    assign fifo_count    = count_q;
    assign reject_count  = rej_q;
endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader against a queue-based reference model.
// Directed sequences cover latency, full buffer, divide-by-zero and flush.
module tb_instr_loader;
    import instr_register_pkg::*;

    localparam int DEPTH = 4;
    localparam int SP    = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    opcode_t    in_opcode;
    operand_t   in_operand_a;
    operand_t   in_operand_b;
    logic       pause;
    logic       load_en;
    address_t   write_pointer;
    opcode_t    opcode;
    operand_t   operand_a;
    operand_t   operand_b;
    logic [2:0] fifo_count;
    logic [7:0] reject_count;

    instr_loader #(.FIFO_DEPTH(DEPTH), .START_PTR(SP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_operand_a(in_operand_a),
        .in_operand_b(in_operand_b), .pause(pause),
        .load_en(load_en), .write_pointer(write_pointer),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .fifo_count(fifo_count), .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

`ifdef INSTR_LOADER_DIVZERO_FILTER_EN
    bit filt_en = 1'b1;
`else
    bit filt_en = 1'b0;
`endif

    // reference model state
    instr_t   mq[$];
    instr_t   src[$];
    bit       m_load;
    instr_t   m_last;
    address_t m_ptr;
    int       m_rej;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_drop(input instr_t h);
        return filt_en && (h.opc == DIV || h.opc == MOD) && (h.op_b == 0);
    endfunction

    function automatic instr_t rand_instr(input bit allow_zero);
        instr_t t;
        t.opc  = opcode_t'(4'($urandom_range(0, 7)));
        t.op_a = operand_t'($urandom);
        t.op_b = operand_t'($urandom);
        if (allow_zero && $urandom_range(0, 3) == 0) t.op_b = 0;
        if (t.op_b == 0 && !allow_zero) t.op_b = 1;
        return t;
    endfunction

    task automatic model_reset();
        mq.delete();
        src.delete();
        m_load = 1'b0;
        m_last = '{opc: ZERO, op_a: 0, op_b: 0};
        m_ptr  = address_t'(SP);
        m_rej  = 0;
    endtask

    task automatic check_out();
        chk("load_en", load_en, m_load);
        chk("opcode", opcode, m_last.opc);
        chk("operand_a", operand_a, m_last.op_a);
        chk("operand_b", operand_b, m_last.op_b);
        chk("wptr", write_pointer, m_ptr);
        chk("count", fifo_count, mq.size());
        chk("in_ready", in_ready, mq.size() != DEPTH);
        chk("reject", reject_count, m_rej);
    endtask

    // one clock: drive at negedge, advance model, check at next negedge
    task automatic tick(input bit v_en, input bit p);
        instr_t nw;
        instr_t h;
        bit     acc;
        nw = (src.size() != 0) ? src[0] : rand_instr(1'b1);
        in_valid     = v_en && (src.size() != 0);
        in_opcode    = nw.opc;
        in_operand_a = nw.op_a;
        in_operand_b = nw.op_b;
        pause        = p;
        acc = in_valid && (mq.size() != DEPTH);
        if (m_load) m_ptr = m_ptr + 5'd1;
        m_load = 1'b0;
        if (!p && mq.size() != 0) begin
            h = mq.pop_front();
            if (is_drop(h)) begin
                if (m_rej < 255) m_rej++;
            end else begin
                m_load = 1'b1;
                m_last = h;
            end
        end
        if (acc) begin
            mq.push_back(nw);
            void'(src.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic do_reset(input bit p);
        reset    = 1'b1;
        in_valid = 1'($urandom);
        pause    = p;
        #1;
        chk("ready_in_reset", in_ready, 1'b0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        opcode_t first_op;
        address_t first_ptr;
        reset        = 1'b1;
        in_valid     = 1'b0;
        pause        = 1'b0;
        in_opcode    = ZERO;
        in_operand_a = 0;
        in_operand_b = 0;
        do_reset(1'b0);

        // single instruction latency
        src.push_back('{opc: ADD, op_a: 5, op_b: 3});
        tick(1'b1, 1'b0);
        chk("lat_early", load_en, 1'b0);
        tick(1'b0, 1'b0);
        chk("lat_load", load_en, 1'b1);
        chk("lat_op", opcode, ADD);
        chk("lat_a", operand_a, 5);
        chk("lat_b", operand_b, 3);
        chk("lat_ptr", write_pointer, 0);

        // fill while paused, fifth held by producer
        do_reset(1'b1);
        for (int i = 0; i < 5; i++)
            src.push_back('{opc: ADD, op_a: 100 + i, op_b: 1});
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        chk("full_count", fifo_count, 4);
        chk("full_ready", in_ready, 1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            if (load_en) begin
                chk("full_ptr", write_pointer, n);
                chk("full_a", operand_a, 100 + n);
                n++;
            end
        end
        chk("full_nloads", n, 5);

        // divide-by-zero filtering
        do_reset(1'b0);
        src.push_back('{opc: DIV, op_a: 10, op_b: 0});
        src.push_back('{opc: SUB, op_a: 7, op_b: 2});
        n = 0;
        first_op = ZERO;
        first_ptr = '1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0);
            if (load_en) begin
                if (n == 0) begin
                    first_op = opcode;
                    first_ptr = write_pointer;
                end
                n++;
            end
        end
        chk("dz_nloads", n, filt_en ? 1 : 2);
        chk("dz_first_op", first_op, filt_en ? SUB : DIV);
        chk("dz_first_ptr", first_ptr, 0);
        chk("dz_last_op", opcode, SUB);
        chk("dz_reject", reject_count, filt_en ? 1 : 0);

        // continuous stream
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            src.push_back(rand_instr(1'b0));
            tick(1'b1, 1'b0);
            chk("stream_cnt_le1", fifo_count <= 1, 1'b1);
            if (i >= 1) chk("stream_load", load_en, 1'b1);
        end

        // flush with entries buffered and a pop pending
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) src.push_back(rand_instr(1'b0));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        chk("flush_pre_cnt", fifo_count, 3);
        do_reset(1'b0);
        chk("flush_load", load_en, 1'b0);
        chk("flush_cnt", fifo_count, 0);
        chk("flush_ptr", write_pointer, SP);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            chk("flush_noload", load_en, 1'b0);
        end

        // random traffic, long enough for pointer wrap
        do_reset(1'b0);
        for (int i = 0; i < 800; i++) begin
            if (src.size() < 3) src.push_back(rand_instr(1'b1));
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1'($urandom));
            end else begin
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
            end
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        chk("drain_cnt", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
